muacm_in_framer: RTL and testbench

//  Device->host (IN) transmit framer for the muacm core, in the clk_usb domain.

---
 rtl/muacm_pkg.sv | 14 +
 rtl/muacm_skid.sv | 49 ++++
 rtl/muacm_in_framer.sv | 128 ++++++++++++
 tb/tb_muacm_in_framer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muacm_pkg.sv
// Shared FSM encoding and default sizing for the muacm IN-path framer.
package muacm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int MAX_PKT_DEF  = 64;
  localparam int IDLE_CYC_DEF = 4800;
  localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/muacm_skid.sv
// Two-entry valid/ready skid buffer; full-rate, one cycle of latency.
module muacm_skid #(
  parameter int W = 9
) (
  input  logic         clk_usb,
  input  logic         rst_usb,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         en;
  logic         push;
  logic         pop;

  // en holds s_ready low until the first clock after reset release
  assign s_ready = en & (cnt != 2'd2);
  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[rp];
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      en     <= 1'b0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      en <= 1'b1;
      if (push) begin
        mem[wp] <= s_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/muacm_in_framer.sv
// Device->host IN framer: packetises bytes, flushes short packets on idle.
// Define MUACM_IN_FRAMER_STATS_EN to add byte/packet statistics counters.
module muacm_in_framer
  import muacm_pkg::*;
#(
  parameter int MAX_PKT  = MAX_PKT_DEF,
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk_usb,
  input  logic        rst_usb,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  in_data,
  output logic        in_last,
  output logic        in_valid,
  input  logic        in_ready,
  output logic        in_flush_now,
  output logic        in_flush_time,
  output logic        pkt_open
`ifdef MUACM_IN_FRAMER_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_bytes,
  output logic [15:0] stat_pkts
`endif
);

  localparam int PW = $clog2(MAX_PKT);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    pcnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [8:0]       q_word;
  logic [7:0]       q_data;
  logic             q_last;
  logic             q_valid;
  logic             q_ready;
  logic             beat;
  logic             s_fire;
  logic             timeout;

  muacm_skid #(.W(9)) u_skid (
    .clk_usb (clk_usb),
    .rst_usb (rst_usb),
    .s_data  ({s_last, s_data}),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (q_word),
    .m_valid (q_valid),
    .m_ready (q_ready)
  );

  assign q_last        = q_word[8];
  assign q_data        = q_word[7:0];
  assign in_valid      = q_valid & (state != FLUSH);
  assign q_ready       = in_ready & (state != FLUSH);
  assign in_data       = q_data;
  assign in_last       = (pcnt == PW'(MAX_PKT - 1)) | q_last;
  assign in_flush_time = 1'b0;
  assign beat          = in_valid & in_ready;
  assign s_fire        = s_valid & s_ready;

  // a byte in flight (buffered or arriving now) always beats the timeout
  assign timeout = (idle_cnt == CNT_W'(IDLE_CYC - 1)) & ~q_valid & ~s_fire;

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (beat & ~in_last) state_nxt = FILL;
      FILL: begin
        if (beat & in_last) state_nxt = IDLE;
        else if (timeout)   state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_flush_now = 1'b0;
    pkt_open     = 1'b0;
    unique case (state)
      FILL:    pkt_open     = 1'b1;
      FLUSH:   in_flush_now = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb)             pcnt <= '0;
    else if (state == FLUSH) pcnt <= '0;
    else if (beat)           pcnt <= in_last ? '0 : pcnt + 1'b1;
  end

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb)
      idle_cnt <= '0;
    else if ((state != FILL) | beat)
      idle_cnt <= '0;
    else if (idle_cnt != CNT_W'(IDLE_CYC - 1))
      idle_cnt <= idle_cnt + 1'b1;
  end

`ifdef MUACM_IN_FRAMER_STATS_EN
  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      stat_bytes <= '0;
      stat_pkts  <= '0;
    end else if (stat_clr) begin
      stat_bytes <= '0;
      stat_pkts  <= '0;
    end else begin
      if (beat) stat_bytes <= stat_bytes + 1'b1;
      if ((beat & in_last) | in_flush_now) stat_pkts <= stat_pkts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_muacm_in_framer.sv
// Bench for muacm_in_framer: vector table, random traffic vs queue model,
// and directed timeout / reset corner cases.
module tb_muacm_in_framer;

  localparam int IDLE_CYC = 4800;
  localparam int MAX_PKT  = 64;

  logic       clk_usb = 1'b0;
  logic       rst_usb;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       in_flush_now;
  logic       in_flush_time;
  logic       pkt_open;

  muacm_in_framer dut (
    .clk_usb       (clk_usb),
    .rst_usb       (rst_usb),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flush_now  (in_flush_now),
    .in_flush_time (in_flush_time),
    .pkt_open      (pkt_open)
  );

  always #5 clk_usb = ~clk_usb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_d[$];
  logic       tx_l[$];
  logic       ex_l[$];

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       el;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l, input logic el);
    tx_d.push_back(d);
    tx_l.push_back(l);
    ex_l.push_back(el);
  endtask

  // Drives the queued bytes, checks every output beat against the queue.
  task automatic xfer(input string nm, input int rdy_pct, input int val_pct,
                      output int cycles);
    int n, si, oi, budget, flushes, unstable;
    logic stall;
    logic [7:0] pd;
    logic pl;
    n = tx_d.size();
    si = 0; oi = 0; cycles = 0; flushes = 0; unstable = 0;
    budget = 40 * n + 100;
    stall = 1'b0; pd = '0; pl = 1'b0;
    while (oi < n && cycles < budget) begin
      s_valid = (si < n) && ($urandom_range(99) < val_pct);
      if (si < n) begin
        s_data = tx_d[si];
        s_last = tx_l[si];
      end
      in_ready = ($urandom_range(99) < rdy_pct);
      if (in_flush_now) flushes++;
      if (stall && (!in_valid || in_data !== pd || in_last !== pl))
        unstable++;
      if (in_valid && in_ready) begin
        chk({nm, "_data"}, 32'(in_data), 32'(tx_d[oi]));
        chk({nm, "_last"}, 32'(in_last), 32'(ex_l[oi]));
        oi++;
      end
      stall = in_valid && !in_ready;
      pd = in_data;
      pl = in_last;
      if (s_valid && s_ready) si++;
      step();
      cycles++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    in_ready = 1'b1;
    chk({nm, "_done"}, 32'(oi), 32'(n));
    chk({nm, "_noflush"}, 32'(flushes), 0);
    chk({nm, "_stable"}, 32'(unstable), 0);
    tx_d.delete();
    tx_l.delete();
    ex_l.delete();
  endtask

  // Idles for up to max cycles, recording flush pulses and pkt_open around the first.
  task automatic wait_flush(input int max, output int at, output int pulses,
                            output logic po_prev, output logic po_at);
    logic po_last;
    at = -1; pulses = 0; po_prev = 1'bx; po_at = 1'bx; po_last = pkt_open;
    for (int k = 0; k < max; k++) begin
      if (in_flush_now) begin
        pulses++;
        if (at < 0) begin
          at = k;
          po_prev = po_last;
          po_at = pkt_open;
        end
      end
      po_last = pkt_open;
      step();
    end
  endtask

  initial begin
    int cyc, at, pulses, pos, bad;
    logic po_prev, po_at, el;
    logic [7:0] d;

    rst_usb = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    in_ready = 1'b0;
    repeat (2) step();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_in_valid", 32'(in_valid), 0);
    chk("rst_in_last", 32'(in_last), 0);
    chk("rst_in_data", 32'(in_data), 0);
    chk("rst_flush", 32'(in_flush_now), 0);
    chk("rst_pkt_open", 32'(pkt_open), 0);
    chk("rst_flush_time", 32'(in_flush_time), 0);
    rst_usb = 1'b0;
    #1;
    chk("rel_s_ready_low", 32'(s_ready), 0);
    step();
    chk("rel_s_ready_high", 32'(s_ready), 1);

    // 1: full packet back to back
    for (int i = 0; i < MAX_PKT; i++)
      push(8'(i), 1'b0, i == MAX_PKT - 1);
    xfer("t1", 100, 100, cyc);
    chk("t1_cycles", 32'(cyc), 65);
    chk("t1_closed", 32'(pkt_open), 0);

    // 2: short packet forced out by the idle timeout
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 1'b0, 1'b0);
    xfer("t2", 100, 100, cyc);
    chk("t2_open", 32'(pkt_open), 1);
    wait_flush(IDLE_CYC + 20, at, pulses, po_prev, po_at);
    chk("t2_flush_at", 32'(at), 32'(IDLE_CYC));
    chk("t2_pulses", 32'(pulses), 1);
    chk("t2_open_before", 32'(po_prev), 1);
    chk("t2_open_at", 32'(po_at), 0);
    chk("t2_open_after", 32'(pkt_open), 0);

    // 3: upstream last closes packets early; vector table
    tbl[0] = '{8'h11, 1'b0, 1'b0};
    tbl[1] = '{8'h22, 1'b0, 1'b0};
    tbl[2] = '{8'h33, 1'b0, 1'b0};
    tbl[3] = '{8'h44, 1'b0, 1'b0};
    tbl[4] = '{8'h55, 1'b1, 1'b1};
    tbl[5] = '{8'h66, 1'b1, 1'b1};
    tbl[6] = '{8'h77, 1'b0, 1'b0};
    tbl[7] = '{8'h88, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) push(tbl[i].d, tbl[i].l, tbl[i].el);
    xfer("t3", 100, 100, cyc);
    chk("t3_closed", 32'(pkt_open), 0);
    wait_flush(IDLE_CYC + 20, at, pulses, po_prev, po_at);
    chk("t3_no_flush", 32'(pulses), 0);

    // 4: random data and backpressure vs packet-position model
    pos = 0;
    for (int i = 0; i < 1000; i++) begin
      d = 8'($urandom);
      el = (pos == MAX_PKT - 1);
      push(d, 1'b0, el);
      pos = el ? 0 : pos + 1;
    end
    xfer("t4", 50, 70, cyc);
    chk("t4_open", 32'(pkt_open), (pos != 0) ? 1 : 0);
    wait_flush(IDLE_CYC + 20, at, pulses, po_prev, po_at);
    chk("t4_tail_flush", 32'(at), 32'(IDLE_CYC));

    // 5: byte arrives in the exact timeout cycle
    push(8'h01, 1'b0, 1'b0);
    xfer("t5a", 100, 100, cyc);
    repeat (IDLE_CYC - 1) step();
    chk("t5_pre_flush", 32'(in_flush_now), 0);
    chk("t5_pre_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data = 8'h02;
    s_last = 1'b0;
    step();
    s_valid = 1'b0;
    chk("t5_flush", 32'(in_flush_now), 0);
    chk("t5_valid", 32'(in_valid), 1);
    chk("t5_data", 32'(in_data), 32'h02);
    chk("t5_last", 32'(in_last), 0);
    step();
    wait_flush(IDLE_CYC / 2, at, pulses, po_prev, po_at);
    chk("t5_restart", 32'(pulses), 0);
    for (int i = 0; i < MAX_PKT - 2; i++)
      push(8'(8'h10 + i), 1'b0, i == MAX_PKT - 3);
    xfer("t5b", 100, 100, cyc);
    chk("t5_closed", 32'(pkt_open), 0);

    // 6: reset with a partial packet and a full skid buffer
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0, 1'b0);
    xfer("t6a", 100, 100, cyc);
    in_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data = 8'(8'h40 + i);
      step();
    end
    chk("t6_full", 32'(s_ready), 0);
    chk("t6_pend", 32'(in_valid), 1);
    rst_usb = 1'b1;
    #1;
    bad = 0;
    if (s_ready !== 1'b0) bad++;
    if (in_valid !== 1'b0) bad++;
    if (in_last !== 1'b0) bad++;
    if (in_data !== 8'h00) bad++;
    if (in_flush_now !== 1'b0) bad++;
    if (pkt_open !== 1'b0) bad++;
    chk("t6_async_rst", 32'(bad), 0);
    s_valid = 1'b0;
    in_ready = 1'b1;
    step();
    rst_usb = 1'b0;
    step();
    chk("t6_ready", 32'(s_ready), 1);
    chk("t6_empty", 32'(in_valid), 0);
    for (int i = 0; i < MAX_PKT; i++)
      push(8'(8'hA5 + i), 1'b0, i == MAX_PKT - 1);
    xfer("t6b", 100, 100, cyc);
    chk("t6_cycles", 32'(cyc), 65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
